rca_wb_sequencer: RTL and testbench
===================================

Name: rca_wb_sequencer

Overview:
- Sits directly downstream of the RCA result side of the CPU/RCA interface.
- Captures completed RCA result bundles: one ID, up to NUM_WRITE_PORTS destination registers with data.
- Buffers them in a small FIFO and serialises each valid destination onto the CPU's single register-file writeback port.
- Emits a retire pulse per bundle so the issue logic can free its ID.

Parameters:
- XLEN, 32, data width.
- NUM_WRITE_PORTS, 5, result ports per RCA bundle.
- MAX_IDS, 8, instruction ID space; ID width is clog2(MAX_IDS).
- FIFO_DEPTH, 2, bundles buffered; must be a power of two and at least 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- done  in  1  RCA presents a result bundle.
- wb_id  in  clog2(MAX_IDS)  bundle instruction ID.
- rd  in  NUM_WRITE_PORTS x XLEN  result data, port 0 to port 4.
- dest_reg_addrs  in  NUM_WRITE_PORTS x 5  destination register per port.
- dest_valid  in  NUM_WRITE_PORTS  port holds a real result.
- ack  out  1  bundle accepted this cycle.
- rf_wb_valid  out  1  writeback request to the register file.
- rf_wb_addr  out  5  destination register.
- rf_wb_data  out  XLEN  write data.
- rf_wb_id  out  clog2(MAX_IDS)  ID of the head bundle.
- rf_wb_ack  in  1  register file took the write.
- retire_valid  out  1  one-cycle pulse: head bundle fully written.
- retire_id  out  clog2(MAX_IDS)  ID being retired.

Behaviour:
- Reset: FIFO empty and pending masks cleared. ack, rf_wb_valid and retire_valid are 0. rf_wb_addr, rf_wb_data, rf_wb_id and retire_id are 0. Any bundle in flight is discarded; reset has priority over every other event.
- Accept:
  - ack = done && !full. It is combinational from done and the registered full flag only; it never depends on a pop in the same cycle (no full-bypass).
  - On the ack edge the bundle is written at the tail. Its stored mask is dest_valid with every bit cleared whose dest_reg_addrs entry is 0 (x0 writes are dropped).
  - done with full: ack = 0. The RCA holds done and the bundle until ack.
- Drain FSM on the head entry, states EMPTY, DRAIN, RETIRE:
  - EMPTY -> DRAIN when count > 0.
  - In DRAIN, sel is the lowest-index set bit of the head mask.
    - rf_wb_valid = 1 while the mask is non-zero.
    - Outputs are rf_wb_addr = head addr[sel], rf_wb_data = head rd[sel], rf_wb_id = head id.
    - On rf_wb_valid && rf_wb_ack, bit sel is cleared.
    - rf_wb_valid stays 1 and the outputs stay stable until rf_wb_ack.
  - DRAIN -> RETIRE when the mask is zero after the update, including a bundle whose mask was zero on entry.
  - RETIRE lasts one cycle:
    - retire_valid = 1 and retire_id = head id.
    - The head is popped.
    - Next state is DRAIN if count after the pop is > 0, else EMPTY.
    - rf_wb_valid = 0 during RETIRE.
- Latency and throughput:
  - A bundle accepted at edge N can drive rf_wb_valid at cycle N+1 at the earliest.
  - k writes with rf_wb_ack held high take k cycles, plus 1 cycle for RETIRE.
  - A bundle with a zero mask retires 2 cycles after acceptance, with no write.
- Simultaneous push and pop: legal when count is between 1 and FIFO_DEPTH-1. Count is unchanged and the pointers wrap modulo FIFO_DEPTH.
- Ordering: strict FIFO, so bundles retire in acceptance order. Within a bundle, writes are issued in ascending port index.
- rf_wb_ack while rf_wb_valid = 0 is ignored.

Decomposition:
- rca_config package holds:
  - NUM_WRITE_PORTS.
  - A new typedef rca_wb_bundle_t containing id, rd[NUM_WRITE_PORTS], addr[NUM_WRITE_PORTS] and mask.
  - A state enum rca_wb_state_t with EMPTY, DRAIN, RETIRE.
- One sub-module, rca_wb_bundle_fifo:
  - A parameterised register FIFO of rca_wb_bundle_t with push, pop, head, full, empty and count.
  - Head mask update is done in place through a clear-bit input.
- The priority encoder is a function in the package.

Test Plan:
1. Single bundle: id=3, dest_valid=5'b10101, addrs x5/x6/x7/x8/x9, rd=0xA0..0xA4, rf_wb_ack held high.
   - Expect writes (x5,0xA0), (x7,0xA2), (x9,0xA4) on consecutive cycles.
   - Then retire_valid with retire_id=3, exactly once.
2. x0 filter: dest_valid=5'b00011, addrs x0 and x4.
   - Expect one write to x4 only, then retire.
   - An all-x0 bundle retires with no write 2 cycles after ack.
3. Backpressure: rf_wb_ack low for 4 cycles mid-bundle.
   - rf_wb_valid, rf_wb_addr and rf_wb_data are stable for all 4 cycles.
   - No write is skipped or duplicated.
4. Full FIFO: present 3 bundles back-to-back with FIFO_DEPTH=2 and rf_wb_ack low.
   - ack=1 for the first two, 0 for the third.
   - The third is accepted on the cycle after the first RETIRE (no bypass).
   - Retire order is 1, 2, 3.
5. Reset mid-drain: assert rst during DRAIN of a 3-write bundle after 1 write.
   - Next cycle: all outputs 0, no retire_valid.
   - A new bundle after reset drains normally.
6. Wrap-around: stream 10 bundles with random masks and random rf_wb_ack.
   - A scoreboard checks the write sequence and the retire IDs against a reference queue.

Source files
------------

// File: rtl/rca_wb_sequencer_pkg.sv
// Shared types, widths and helpers for the RCA writeback sequencer.
package rca_config;

  localparam int unsigned XLEN            = 32;
  localparam int unsigned NUM_WRITE_PORTS = 5;
  localparam int unsigned MAX_IDS         = 8;
  localparam int unsigned REG_W           = 5;
  localparam int unsigned ID_W  = (MAX_IDS > 1) ? $clog2(MAX_IDS) : 1;
  localparam int unsigned SEL_W = (NUM_WRITE_PORTS > 1) ? $clog2(NUM_WRITE_PORTS) : 1;

  typedef logic [ID_W-1:0]                             rca_id_t;
  typedef logic [SEL_W-1:0]                            rca_sel_t;
  typedef logic [NUM_WRITE_PORTS-1:0]                  rca_port_mask_t;
  typedef logic [NUM_WRITE_PORTS-1:0][XLEN-1:0]        rca_port_data_t;
  typedef logic [NUM_WRITE_PORTS-1:0][REG_W-1:0]       rca_port_addr_t;

  // One buffered RCA result bundle; mask marks ports still owed a writeback.
  typedef struct packed {
    rca_id_t        id;
    rca_port_data_t rd;
    rca_port_addr_t addr;
    rca_port_mask_t mask;
  } rca_wb_bundle_t;

  typedef enum logic [1:0] {
    StEmpty,
    StDrain,
    StRetire
  } rca_wb_state_t;

  // Index of the lowest set bit; 0 when the mask is empty.
  function automatic rca_sel_t lowest_set(input rca_port_mask_t mask);
    rca_sel_t sel;
    sel = '0;
    for (int i = NUM_WRITE_PORTS - 1; i >= 0; i--) begin
      if (mask[i]) sel = rca_sel_t'(i);
    end
    return sel;
  endfunction

  // Writes to x0 have no architectural effect, so they never enter the mask.
  function automatic rca_port_mask_t drop_x0(input rca_port_mask_t valid,
                                             input rca_port_addr_t addr);
    rca_port_mask_t m;
    for (int i = 0; i < NUM_WRITE_PORTS; i++) begin
      m[i] = valid[i] & (addr[i] != '0);
    end
    return m;
  endfunction

endpackage

// File: rtl/rca_wb_sequencer_if.sv
// RCA result side plus register-file writeback / retire side of the sequencer.
interface rca_wb_sequencer_if;

  logic                       done;
  rca_config::rca_id_t        wb_id;
  rca_config::rca_port_data_t rd;
  rca_config::rca_port_addr_t dest_reg_addrs;
  rca_config::rca_port_mask_t dest_valid;
  logic                       ack;

  logic                       rf_wb_valid;
  logic [4:0]                 rf_wb_addr;
  logic [rca_config::XLEN-1:0] rf_wb_data;
  rca_config::rca_id_t        rf_wb_id;
  logic                       rf_wb_ack;

  logic                       retire_valid;
  rca_config::rca_id_t        retire_id;

  // Environment side: RCA producer and register file.
  modport master (
    output done, wb_id, rd, dest_reg_addrs, dest_valid, rf_wb_ack,
    input  ack, rf_wb_valid, rf_wb_addr, rf_wb_data, rf_wb_id, retire_valid, retire_id
  );

  // Sequencer side.
  modport slave (
    input  done, wb_id, rd, dest_reg_addrs, dest_valid, rf_wb_ack,
    output ack, rf_wb_valid, rf_wb_addr, rf_wb_data, rf_wb_id, retire_valid, retire_id
  );

endinterface

// File: rtl/rca_wb_sequencer_bundle_fifo.sv
// Register FIFO of result bundles with in-place clearing of the head mask.
module rca_wb_bundle_fifo import rca_config::*; #(
  parameter int unsigned Depth = 2
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           push_i,
  input  rca_wb_bundle_t                 push_data_i,
  input  logic                           pop_i,
  input  logic                           clr_en_i,
  input  rca_port_mask_t                 clr_mask_i,
  output rca_wb_bundle_t                 head_o,
  output logic                           full_o,
  output logic                           empty_o,
  output logic [$clog2(Depth + 1)-1:0]   count_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  rca_wb_bundle_t  mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            full_q, full_d;
  logic            push_ok, pop_ok;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign push_ok = push_i & ~full_q;
  assign pop_ok  = pop_i & (count_q != '0);

  // Pointer, occupancy and full-flag next state.
  always_comb begin
    wr_ptr_d = push_ok ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop_ok ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    full_d = (count_d == CntW'(Depth));
  end

  // Control state registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
    end
  end

  // Entry storage; only the masks are cleared on reset, payload is don't-care.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < Depth; i++) mem_q[i].mask <= '0;
    end else begin
      if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
      if (clr_en_i) mem_q[rd_ptr_q].mask <= mem_q[rd_ptr_q].mask & ~clr_mask_i;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/rca_wb_sequencer.sv
// Buffers RCA result bundles and serialises them onto the single RF write port.
module rca_wb_sequencer import rca_config::*; #(
  parameter int unsigned FifoDepth = 2
) (
  input logic                clk_i,
  input logic                rst_i,
  rca_wb_sequencer_if.slave  bus_io
);

  localparam int unsigned CntW = $clog2(FifoDepth + 1);

  rca_wb_state_t   state_q, state_d;
  rca_wb_bundle_t  push_bundle, head;
  logic            push, pop, full, empty, clr_en;
  logic [CntW-1:0] count;
  rca_sel_t        sel;
  rca_port_mask_t  sel_onehot, mask_after;

  logic            wb_valid, ret_valid;
  logic [4:0]      wb_addr;
  logic [XLEN-1:0] wb_data;
  rca_id_t         wb_id_out, ret_id;

  // Accept depends only on the registered full flag, never on a same-cycle pop.
  assign push = bus_io.done & ~full;

  // Incoming bundle with x0 destinations stripped from the mask.
  always_comb begin
    push_bundle      = '0;
    push_bundle.id   = bus_io.wb_id;
    push_bundle.rd   = bus_io.rd;
    push_bundle.addr = bus_io.dest_reg_addrs;
    push_bundle.mask = drop_x0(bus_io.dest_valid, bus_io.dest_reg_addrs);
  end

  rca_wb_bundle_fifo #(
    .Depth (FifoDepth)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (push),
    .push_data_i (push_bundle),
    .pop_i       (pop),
    .clr_en_i    (clr_en),
    .clr_mask_i  (sel_onehot),
    .head_o      (head),
    .full_o      (full),
    .empty_o     (empty),
    .count_o     (count)
  );

  assign sel        = lowest_set(head.mask);
  assign sel_onehot = rca_port_mask_t'(1) << sel;

  // Drain FSM next state and all RF / retire outputs.
  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    clr_en     = 1'b0;
    mask_after = head.mask;
    wb_valid   = 1'b0;
    wb_addr    = '0;
    wb_data    = '0;
    wb_id_out  = '0;
    ret_valid  = 1'b0;
    ret_id     = '0;
    unique case (state_q)
      StEmpty: begin
        if (!empty) state_d = StDrain;
      end
      StDrain: begin
        if (head.mask != '0) begin
          wb_valid  = 1'b1;
          wb_addr   = head.addr[sel];
          wb_data   = head.rd[sel];
          wb_id_out = head.id;
          clr_en    = bus_io.rf_wb_ack;
        end
        if (clr_en) mask_after = head.mask & ~sel_onehot;
        if (mask_after == '0) state_d = StRetire;
      end
      StRetire: begin
        ret_valid = 1'b1;
        ret_id    = head.id;
        pop       = 1'b1;
        // Occupancy after this pop, counting a same-cycle accept.
        state_d   = ((count > CntW'(1)) || push) ? StDrain : StEmpty;
      end
      default: state_d = StEmpty;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= StEmpty;
    else       state_q <= state_d;
  end

  assign bus_io.ack          = push;
  assign bus_io.rf_wb_valid  = wb_valid;
  assign bus_io.rf_wb_addr   = wb_addr;
  assign bus_io.rf_wb_data   = wb_data;
  assign bus_io.rf_wb_id     = wb_id_out;
  assign bus_io.retire_valid = ret_valid;
  assign bus_io.retire_id    = ret_id;

endmodule

// File: tb/tb_rca_wb_sequencer.sv
// Directed bench for rca_wb_sequencer with a queue-based reference model.
module tb_rca_wb_sequencer;
  import rca_config::*;

  localparam int FIFO_DEPTH = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  rca_wb_sequencer_if bus ();

  rca_wb_sequencer #(
    .FifoDepth (FIFO_DEPTH)
  ) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus_io (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: bundles accepted but not yet retired, and the writes owed.
  typedef struct {
    int         seq;
    logic [4:0] addr;
    logic [31:0] data;
  } exp_wr_t;

  exp_wr_t     exp_wr[$];
  int          exp_id[$];
  exp_wr_t     e_new;
  int          head_seq = 0;
  int          tail_seq = 0;
  logic        prev_stall = 1'b0;
  logic [4:0]  prev_addr;
  logic [31:0] prev_data;

  // Observed events, for the directed timing checks.
  int          wr_cyc[$];
  int          wr_addr[$];
  logic [31:0] wr_data[$];
  int          rt_cyc[$];
  int          rt_id[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic note_fail(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic clear_logs();
    wr_cyc.delete(); wr_addr.delete(); wr_data.delete();
    rt_cyc.delete(); rt_id.delete();
  endtask

  // Compare process: every non-reset cycle, judged on the falling edge.
  initial begin
    logic pending;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_wr.delete();
        exp_id.delete();
        head_seq   = 0;
        tail_seq   = 0;
        prev_stall = 1'b0;
      end else begin
        check("ack", bus.ack, bus.done && (exp_id.size() < FIFO_DEPTH));
        if (prev_stall) begin
          check("hold_valid", bus.rf_wb_valid, 1);
          check("hold_addr", bus.rf_wb_addr, prev_addr);
          check("hold_data", bus.rf_wb_data, prev_data);
        end
        pending = (exp_wr.size() > 0) && (exp_wr[0].seq == head_seq);
        if (bus.rf_wb_valid) begin
          if (!pending) note_fail("spurious_write", bus.rf_wb_addr, 0);
          else begin
            check("wb_addr", bus.rf_wb_addr, exp_wr[0].addr);
            check("wb_data", bus.rf_wb_data, exp_wr[0].data);
            check("wb_id", bus.rf_wb_id, exp_id[0]);
          end
          if (bus.rf_wb_ack) begin
            wr_cyc.push_back(cyc);
            wr_addr.push_back(int'(bus.rf_wb_addr));
            wr_data.push_back(bus.rf_wb_data);
            if (pending) exp_wr.pop_front();
          end
        end
        if (bus.retire_valid) begin
          if (exp_id.size() == 0) note_fail("spurious_retire", bus.retire_id, 0);
          else begin
            check("retire_complete", pending, 0);
            check("retire_id", bus.retire_id, exp_id[0]);
            exp_id.pop_front();
            head_seq++;
          end
          rt_cyc.push_back(cyc);
          rt_id.push_back(int'(bus.retire_id));
        end
        if (bus.ack) begin
          for (int i = 0; i < NUM_WRITE_PORTS; i++) begin
            if (bus.dest_valid[i] && bus.dest_reg_addrs[i] != 5'd0) begin
              e_new.seq  = tail_seq;
              e_new.addr = bus.dest_reg_addrs[i];
              e_new.data = bus.rd[i];
              exp_wr.push_back(e_new);
            end
          end
          exp_id.push_back(int'(bus.wb_id));
          tail_seq++;
        end
        prev_stall = bus.rf_wb_valid && !bus.rf_wb_ack;
        prev_addr  = bus.rf_wb_addr;
        prev_data  = bus.rf_wb_data;
      end
    end
  end

  // Hold a bundle on the RCA side until it is acknowledged.
  task automatic present(input int id, input rca_port_mask_t dv, input rca_port_addr_t ad,
                         input rca_port_data_t dt, output int ack_cyc, output int waits);
    bus.done           = 1'b1;
    bus.wb_id          = rca_id_t'(id);
    bus.dest_valid     = dv;
    bus.dest_reg_addrs = ad;
    bus.rd             = dt;
    waits   = 0;
    ack_cyc = -1;
    while (ack_cyc < 0) begin
      @(negedge clk);
      if (bus.ack) ack_cyc = cyc;
      else begin
        waits++;
        if (waits > 300) begin
          note_fail("accept_timeout", waits, 0);
          break;
        end
      end
    end
    @(posedge clk); #1;
    bus.done = 1'b0;
  endtask

  task automatic wait_retires(input int n);
    int k = 0;
    while (rt_id.size() < n && k < 300) begin
      @(posedge clk);
      k++;
    end
    if (rt_id.size() < n) note_fail("retire_timeout", rt_id.size(), n);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic wait_valid();
    int k = 0;
    do begin
      @(posedge clk); #1;
      k++;
    end while (!bus.rf_wb_valid && k < 50);
    if (!bus.rf_wb_valid) note_fail("valid_timeout", k, 0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_ack"}, bus.ack, 0);
    check({tag, "_valid"}, bus.rf_wb_valid, 0);
    check({tag, "_addr"}, bus.rf_wb_addr, 0);
    check({tag, "_data"}, bus.rf_wb_data, 0);
    check({tag, "_id"}, bus.rf_wb_id, 0);
    check({tag, "_retire"}, bus.retire_valid, 0);
    check({tag, "_retire_id"}, bus.retire_id, 0);
  endtask

  rca_port_mask_t dv;
  rca_port_addr_t ad;
  rca_port_data_t dt;
  int a, a1, a2, a3, w1, w2, w3, exp_total;
  bit stream_done;

  initial begin
    bus.done = 1'b0; bus.wb_id = '0; bus.dest_valid = '0;
    bus.dest_reg_addrs = '0; bus.rd = '0; bus.rf_wb_ack = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk); #1;

    // 1: three writes on consecutive cycles, then a single retire.
    clear_logs();
    bus.rf_wb_ack = 1'b1;
    dv = 5'b10101;
    for (int i = 0; i < 5; i++) begin ad[i] = 5'(5 + i); dt[i] = 32'hA0 + i; end
    present(3, dv, ad, dt, a, w1);
    wait_retires(1);
    check("t1_wr_n", wr_addr.size(), 3);
    if (wr_addr.size() == 3) begin
      check("t1_wr0_addr", wr_addr[0], 5);  check("t1_wr0_data", wr_data[0], 32'hA0);
      check("t1_wr1_addr", wr_addr[1], 7);  check("t1_wr1_data", wr_data[1], 32'hA2);
      check("t1_wr2_addr", wr_addr[2], 9);  check("t1_wr2_data", wr_data[2], 32'hA4);
      check("t1_wr0_cyc", wr_cyc[0], a + 2);
      check("t1_wr2_cyc", wr_cyc[2], a + 4);
    end
    check("t1_rt_n", rt_id.size(), 1);
    if (rt_id.size() == 1) begin
      check("t1_rt_id", rt_id[0], 3);
      check("t1_rt_cyc", rt_cyc[0], a + 5);
    end

    // 2a: the x0 port is dropped, only x4 is written.
    clear_logs();
    dv = 5'b00011;
    ad[0] = 5'd0; ad[1] = 5'd4; ad[2] = 5'd1; ad[3] = 5'd2; ad[4] = 5'd3;
    for (int i = 0; i < 5; i++) dt[i] = 32'hB0 + i;
    present(1, dv, ad, dt, a, w1);
    wait_retires(1);
    check("t2_wr_n", wr_addr.size(), 1);
    if (wr_addr.size() == 1) begin
      check("t2_wr_addr", wr_addr[0], 4);
      check("t2_wr_data", wr_data[0], 32'hB1);
    end
    check("t2_rt_n", rt_id.size(), 1);
    if (rt_id.size() == 1) check("t2_rt_cyc", rt_cyc[0], a + 3);

    // 2b: all-x0 bundle retires two cycles after acceptance with no write.
    clear_logs();
    dv = 5'b11111;
    ad = '0;
    present(2, dv, ad, dt, a, w1);
    wait_retires(1);
    check("t2b_wr_n", wr_addr.size(), 0);
    if (rt_id.size() == 1) begin
      check("t2b_rt_id", rt_id[0], 2);
      check("t2b_rt_cyc", rt_cyc[0], a + 3);
    end

    // 3: four stall cycles on the second write of a bundle.
    clear_logs();
    bus.rf_wb_ack = 1'b0;
    dv = 5'b00111;
    for (int i = 0; i < 5; i++) begin ad[i] = 5'(10 + i); dt[i] = 32'hC0 + i; end
    present(4, dv, ad, dt, a, w1);
    wait_valid();
    bus.rf_wb_ack = 1'b1;
    @(posedge clk); #1;
    bus.rf_wb_ack = 1'b0;
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      check("t3_stall_valid", bus.rf_wb_valid, 1);
      check("t3_stall_addr", bus.rf_wb_addr, 11);
      check("t3_stall_data", bus.rf_wb_data, 32'hC1);
    end
    @(posedge clk); #1;
    bus.rf_wb_ack = 1'b1;
    wait_retires(1);
    check("t3_wr_n", wr_addr.size(), 3);
    if (wr_addr.size() == 3) begin
      check("t3_wr0", wr_addr[0], 10);
      check("t3_wr1", wr_addr[1], 11);
      check("t3_wr2", wr_addr[2], 12);
      check("t3_gap", wr_cyc[1] - wr_cyc[0], 5);
    end
    if (rt_id.size() == 1) check("t3_rt_id", rt_id[0], 4);

    // 4: third bundle waits for the first retire; no same-cycle bypass.
    clear_logs();
    bus.rf_wb_ack = 1'b0;
    dv = 5'b00001;
    fork
      begin
        ad[0] = 5'd20; dt[0] = 32'hD0; present(1, dv, ad, dt, a1, w1);
        ad[0] = 5'd21; dt[0] = 32'hD1; present(2, dv, ad, dt, a2, w2);
        ad[0] = 5'd22; dt[0] = 32'hD2; present(3, dv, ad, dt, a3, w3);
      end
      begin
        repeat (8) @(posedge clk);
        #1;
        bus.rf_wb_ack = 1'b1;
      end
    join
    wait_retires(3);
    check("t4_first_wait", w1, 0);
    check("t4_second_wait", w2, 0);
    check("t4_back_to_back", a2, a1 + 1);
    check("t4_third_blocked", w3 > 0, 1);
    check("t4_rt_n", rt_id.size(), 3);
    if (rt_id.size() == 3) begin
      check("t4_third_accept", a3, rt_cyc[0] + 1);
      check("t4_rt0", rt_id[0], 1);
      check("t4_rt1", rt_id[1], 2);
      check("t4_rt2", rt_id[2], 3);
    end

    // 5: reset after the first of three writes.
    clear_logs();
    bus.rf_wb_ack = 1'b1;
    dv = 5'b00111;
    for (int i = 0; i < 5; i++) begin ad[i] = 5'(13 + i); dt[i] = 32'hE0 + i; end
    present(5, dv, ad, dt, a, w1);
    wait_valid();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_zero_outputs("t5_post_reset");
    repeat (6) @(posedge clk); #1;
    check("t5_no_retire", rt_id.size(), 0);
    check("t5_one_write", wr_addr.size(), 1);
    clear_logs();
    dv = 5'b00110;
    for (int i = 0; i < 5; i++) begin ad[i] = 5'(16 + i); dt[i] = 32'hF0 + i; end
    present(6, dv, ad, dt, a, w1);
    wait_retires(1);
    check("t5_new_wr_n", wr_addr.size(), 2);
    if (wr_addr.size() == 2) begin
      check("t5_new_wr0", wr_addr[0], 17);
      check("t5_new_wr1", wr_addr[1], 18);
    end
    if (rt_id.size() == 1) check("t5_new_rt_id", rt_id[0], 6);

    // 6: ten random bundles with random write backpressure, wrapping the FIFO.
    clear_logs();
    exp_total   = 0;
    stream_done = 1'b0;
    fork
      begin
        for (int b = 0; b < 10; b++) begin
          dv = rca_port_mask_t'($urandom);
          for (int i = 0; i < 5; i++) begin
            ad[i] = 5'($urandom_range(0, 7));
            dt[i] = $urandom;
            if (dv[i] && ad[i] != 5'd0) exp_total++;
          end
          present(b % 8, dv, ad, dt, a, w1);
        end
        stream_done = 1'b1;
      end
      begin
        while (!stream_done) begin
          @(posedge clk); #1;
          bus.rf_wb_ack = 1'($urandom_range(0, 1));
        end
      end
    join
    bus.rf_wb_ack = 1'b1;
    wait_retires(10);
    check("t6_wr_n", wr_addr.size(), exp_total);
    check("t6_rt_n", rt_id.size(), 10);
    if (rt_id.size() == 10) begin
      for (int b = 0; b < 10; b++) check("t6_rt_order", rt_id[b], b % 8);
    end
    check("t6_model_empty", exp_id.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
